// File: rtl/onehot_pulse_dec3_8.sv
// Sequential 3-to-8 decoder: buffers indices in a FIFO and replays
// each one as a one-hot pulse held for PULSE_W cycles.
module onehot_pulse_dec3_8 #(
   parameter int PULSE_W = 4,
   parameter int DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   output logic       in_ready,
   output logic [7:0] y,
   output logic       y_valid,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [3:0]    PW_LOAD  = 4'(PULSE_W - 1);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t        state;
   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    cnt;
   logic          push;
   logic          pop;

   function automatic logic [7:0] dec(input logic [2:0] c);
      dec    = 8'd0;
      dec[c] = 1'b1;
   endfunction

   // Ready looks only at registered count, so a same-cycle pop never
   // frees a slot for a push while full.
   assign in_ready = (count < CNT_FULL);
   assign push     = in_valid & in_ready & ~clr;
   assign pop      = (state == IDLE) & (count != '0) & ~clr;
   assign y_valid  = (state == DRIVE);
   assign busy     = (state != IDLE) | (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         y      <= 8'd0;
         cnt    <= 4'd0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         state  <= IDLE;
         y      <= 8'd0;
         cnt    <= 4'd0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
         unique case (state)
            IDLE: begin
               if (pop) begin
                  y     <= dec(mem[rd_ptr]);
                  cnt   <= PW_LOAD;
                  state <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt == 4'd0) begin
                  y     <= 8'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase
      end
   end

endmodule
